// File: rtl/memory_stage_pkg.sv
// Shared constants and types for the memory stage: control-bit positions,
// access-size encodings and FSM state.
package memory_stage_pkg;

    localparam int CST_W     = 17;
    localparam int CST_WE    = 0;
    localparam int CST_LOAD  = 1;
    localparam int CST_STORE = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Address bits that must be zero for a naturally aligned access of size sz.
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_mask = 3'b000;
            SZ_H:    size_mask = 3'b001;
            SZ_W:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
interface memory_stage_if;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [63:0] DMEM_ADDR;
    logic [63:0] DMEM_WDATA;
    logic [7:0]  DMEM_BE;
    logic        DMEM_READY;
    logic [63:0] DMEM_RDATA;

    modport master (
        output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE,
        input  DMEM_READY, DMEM_RDATA
    );

    modport slave (
        input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE,
        output DMEM_READY, DMEM_RDATA
    );
endinterface

// File: rtl/memory_stage_mem_align.sv
// Combinational lane steering: byte enables and shifted store data on the way
// out, right-shift and sign/zero extension of load data on the way back.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  a,
    input  logic [63:0] sdata,
    input  logic [63:0] rdata,
    output logic [7:0]  be,
    output logic [63:0] wdata,
    output logic [63:0] ldata
);
    logic [63:0] sh;

    always_comb begin
        sh    = rdata >> {a, 3'b000};
        wdata = sdata << {a, 3'b000};
        be    = 8'hFF;
        ldata = sh;
        case (funct3[1:0])
            SZ_B: begin
                be    = 8'h01 << a;
                ldata = funct3[2] ? {56'b0, sh[7:0]} : {{56{sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                be    = 8'h03 << a;
                ldata = funct3[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            end
            SZ_W: begin
                be    = 8'h0F << a;
                ldata = funct3[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            end
            default: begin
                be    = 8'hFF;
                ldata = sh;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues data-memory accesses, stalls upstream until the
// memory answers, and registers results toward writeback.
// Optional MEM_MISALIGN_CHECK_EN traps misaligned accesses instead of aligning them.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              MEM_V,
    input  logic [CST_W-1:0]  MEM_Cst,
    input  logic [63:0]       MEM_ALU_RES,
    input  logic [63:0]       MEM_STORE_DATA,
    input  logic              MEM_PC_MUX,
    input  logic [63:0]       MEM_NPC,
    input  logic [31:0]       MEM_IR,
    input  logic [63:0]       MEM_Target_Address,
    input  logic              MEM_FLUSH,
    output logic              MEM_STALL,
    memory_stage_if.master    dmem,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic              MEM_MISALIGN,
`endif
    output logic              WB_V,
    output logic [CST_W-1:0]  WB_Cst,
    output logic [63:0]       WB_RES,
    output logic              WB_PC_MUX,
    output logic [63:0]       WB_NPC,
    output logic [31:0]       WB_IR,
    output logic [63:0]       WB_Target_Address
);
    state_t           state, state_nxt;
    logic             flush_sticky;
    logic [63:0]      lat_res;
    logic [63:0]      lat_sdata;
    logic [2:0]       lat_f3;
    logic [2:0]       lat_a;
    logic             lat_we;

    logic             mem_op, mis, issue, in_wait;
    logic [2:0]       a_cur, a_sel, f3_sel;
    logic [63:0]      addr_sel, sdata_sel;
    logic [CST_W-1:0] cst_out;
    logic [7:0]       al_be;
    logic [63:0]      al_wdata, al_ldata;

    always_comb begin
        mem_op  = MEM_Cst[CST_LOAD] | MEM_Cst[CST_STORE];
        a_cur   = MEM_ALU_RES[2:0];
        mis     = 1'b0;
        cst_out = MEM_Cst;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = MEM_V && mem_op && (state == S_IDLE) &&
              (|(MEM_ALU_RES[2:0] & size_mask(MEM_IR[13:12])));
        if (mis) cst_out[CST_WE] = 1'b0;
`else
        a_cur = MEM_ALU_RES[2:0] & ~size_mask(MEM_IR[13:12]);
`endif
        // Gating with RESET_N keeps the request low during reset even if upstream is live.
        issue   = RESET_N && (state == S_IDLE) && MEM_V && mem_op && !MEM_FLUSH && !mis;
        in_wait = RESET_N && (state == S_WAIT);

        f3_sel    = in_wait ? lat_f3    : MEM_IR[14:12];
        a_sel     = in_wait ? lat_a     : a_cur;
        addr_sel  = in_wait ? lat_res   : MEM_ALU_RES;
        sdata_sel = in_wait ? lat_sdata : MEM_STORE_DATA;

        dmem.DMEM_REQ   = issue || in_wait;
        dmem.DMEM_WE    = dmem.DMEM_REQ && (in_wait ? lat_we : MEM_Cst[CST_STORE]);
        dmem.DMEM_ADDR  = {addr_sel[63:3], 3'b000};
        dmem.DMEM_WDATA = al_wdata;
        dmem.DMEM_BE    = dmem.DMEM_REQ ? al_be : 8'h00;
        MEM_STALL       = (issue || in_wait) && !dmem.DMEM_READY;
    end

    mem_align u_align (
        .funct3 (f3_sel),
        .a      (a_sel),
        .sdata  (sdata_sel),
        .rdata  (dmem.DMEM_RDATA),
        .be     (al_be),
        .wdata  (al_wdata),
        .ldata  (al_ldata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue && !dmem.DMEM_READY) state_nxt = S_WAIT;
            S_WAIT:  if (dmem.DMEM_READY)           state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            flush_sticky      <= 1'b0;
            lat_res           <= '0;
            lat_sdata         <= '0;
            lat_f3            <= '0;
            lat_a             <= '0;
            lat_we            <= 1'b0;
            WB_V              <= 1'b0;
            WB_Cst            <= '0;
            WB_RES            <= '0;
            WB_PC_MUX         <= 1'b0;
            WB_NPC            <= '0;
            WB_IR             <= '0;
            WB_Target_Address <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            MEM_MISALIGN      <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_CHECK_EN
            MEM_MISALIGN <= mis && !MEM_FLUSH;
`endif
            if (state == S_IDLE) begin
                if (issue && !dmem.DMEM_READY) begin
                    // Snapshot the access so the bus stays stable across the wait.
                    lat_res   <= MEM_ALU_RES;
                    lat_sdata <= MEM_STORE_DATA;
                    lat_f3    <= MEM_IR[14:12];
                    lat_a     <= a_cur;
                    lat_we    <= MEM_Cst[CST_STORE];
                    WB_V      <= 1'b0;
                end else begin
                    WB_V              <= MEM_V && !MEM_FLUSH;
                    WB_Cst            <= cst_out;
                    WB_RES            <= (issue && !MEM_Cst[CST_STORE]) ? al_ldata : MEM_ALU_RES;
                    WB_PC_MUX         <= MEM_PC_MUX;
                    WB_NPC            <= MEM_NPC;
                    WB_IR             <= MEM_IR;
                    WB_Target_Address <= MEM_Target_Address;
                end
            end else begin
                if (dmem.DMEM_READY) begin
                    WB_V              <= !(flush_sticky || MEM_FLUSH);
                    WB_Cst            <= MEM_Cst;
                    WB_RES            <= lat_we ? lat_res : al_ldata;
                    WB_PC_MUX         <= MEM_PC_MUX;
                    WB_NPC            <= MEM_NPC;
                    WB_IR             <= MEM_IR;
                    WB_Target_Address <= MEM_Target_Address;
                    flush_sticky      <= 1'b0;
                end else begin
                    WB_V         <= 1'b0;
                    flush_sticky <= flush_sticky || MEM_FLUSH;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected writeback
// results, a negedge monitor pops and compares each WB_V beat.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              MEM_V;
    logic [CST_W-1:0]  MEM_Cst;
    logic [63:0]       MEM_ALU_RES, MEM_STORE_DATA, MEM_NPC, MEM_Target_Address;
    logic              MEM_PC_MUX, MEM_FLUSH, MEM_STALL;
    logic [31:0]       MEM_IR;
    logic              WB_V, WB_PC_MUX;
    logic [CST_W-1:0]  WB_Cst;
    logic [63:0]       WB_RES, WB_NPC, WB_Target_Address;
    logic [31:0]       WB_IR;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              MEM_MISALIGN;
`endif

    memory_stage_if dmem();

    memory_stage dut (
        .CLK                (CLK),
        .RESET_N            (RESET_N),
        .MEM_V              (MEM_V),
        .MEM_Cst            (MEM_Cst),
        .MEM_ALU_RES        (MEM_ALU_RES),
        .MEM_STORE_DATA     (MEM_STORE_DATA),
        .MEM_PC_MUX         (MEM_PC_MUX),
        .MEM_NPC            (MEM_NPC),
        .MEM_IR             (MEM_IR),
        .MEM_Target_Address (MEM_Target_Address),
        .MEM_FLUSH          (MEM_FLUSH),
        .MEM_STALL          (MEM_STALL),
        .dmem               (dmem.master),
`ifdef MEM_MISALIGN_CHECK_EN
        .MEM_MISALIGN       (MEM_MISALIGN),
`endif
        .WB_V               (WB_V),
        .WB_Cst             (WB_Cst),
        .WB_RES             (WB_RES),
        .WB_PC_MUX          (WB_PC_MUX),
        .WB_NPC             (WB_NPC),
        .WB_IR              (WB_IR),
        .WB_Target_Address  (WB_Target_Address)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0]      res;
        logic [CST_W-1:0] cst;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [63:0] res, input logic [CST_W-1:0] cst);
        exp_t e;
        e.res = res;
        e.cst = cst;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [CST_W-1:0] cst, input logic [2:0] f3,
                          input logic [63:0] alu, input logic [63:0] sd, input logic fl);
        MEM_V          = v;
        MEM_Cst        = cst;
        MEM_IR         = {17'h0, f3, 5'h0, 7'h03};
        MEM_ALU_RES    = alu;
        MEM_STORE_DATA = sd;
        MEM_FLUSH      = fl;
    endtask

    // Monitor: every WB_V beat must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (WB_V === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got WB_V=1 res=0x%0h, expected no result", WB_RES);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("wb_res", WB_RES, e.res);
                chk("wb_cst", {47'b0, WB_Cst}, {47'b0, e.cst});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET_N = 1'b0;
        set_in(1'b0, '0, 3'b000, '0, '0, 1'b0);
        MEM_PC_MUX = 1'b0;
        MEM_NPC = 64'h104;
        MEM_Target_Address = 64'h200;
        dmem.DMEM_READY = 1'b0;
        dmem.DMEM_RDATA = '0;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_wb_v",  {63'b0, WB_V}, 64'd0);
        chk("rst_wb_res", WB_RES, 64'd0);
        chk("rst_stall", {63'b0, MEM_STALL}, 64'd0);
        chk("rst_req",   {63'b0, dmem.DMEM_REQ}, 64'd0);
        RESET_N = 1'b1;

        // ALU op, latency 1
        step();
        set_in(1'b1, 17'h1, 3'b000, 64'h1234, '0, 1'b0);
        push(64'h1234, 17'h1);
        @(negedge CLK);
        chk("alu_stall", {63'b0, MEM_STALL}, 64'd0);
        chk("alu_req",   {63'b0, dmem.DMEM_REQ}, 64'd0);

        // LB at byte 3, memory ready immediately
        step();
        set_in(1'b1, 17'h3, 3'b000, 64'h1003, '0, 1'b0);
        dmem.DMEM_READY = 1'b1;
        dmem.DMEM_RDATA = 64'h0000_0000_8000_0000;
        push(64'hFFFF_FFFF_FFFF_FF80, 17'h3);
        @(negedge CLK);
        chk("lb_req",   {63'b0, dmem.DMEM_REQ}, 64'd1);
        chk("lb_be",    {56'b0, dmem.DMEM_BE}, 64'h08);
        chk("lb_addr",  dmem.DMEM_ADDR, 64'h1000);
        chk("lb_stall", {63'b0, MEM_STALL}, 64'd0);

        step();
        set_in(1'b1, 17'h3, 3'b100, 64'h1003, '0, 1'b0);
        push(64'h80, 17'h3);
        @(negedge CLK);
        chk("lbu_be", {56'b0, dmem.DMEM_BE}, 64'h08);

        // SW at 0x4, ready after three stall cycles
        step();
        set_in(1'b1, 17'h4, 3'b010, 64'h4, 64'hDEAD_BEEF, 1'b0);
        dmem.DMEM_READY = 1'b0;
        push(64'h4, 17'h4);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("sw_stall", {63'b0, MEM_STALL}, 64'd1);
            chk("sw_req",   {63'b0, dmem.DMEM_REQ}, 64'd1);
            chk("sw_we",    {63'b0, dmem.DMEM_WE}, 64'd1);
            chk("sw_be",    {56'b0, dmem.DMEM_BE}, 64'hF0);
            chk("sw_wdata", {32'b0, dmem.DMEM_WDATA[63:32]}, 64'hDEAD_BEEF);
            if (i > 0) chk("sw_bubble", {63'b0, WB_V}, 64'd0);
            step();
        end
        dmem.DMEM_READY = 1'b1;
        @(negedge CLK);
        chk("sw_done_stall", {63'b0, MEM_STALL}, 64'd0);
        chk("sw_done_be",    {56'b0, dmem.DMEM_BE}, 64'hF0);

        // LD flushed while waiting: access completes, result discarded
        step();
        set_in(1'b1, 17'h3, 3'b011, 64'h10, '0, 1'b0);
        dmem.DMEM_READY = 1'b0;
        dmem.DMEM_RDATA = 64'hCAFE;
        @(negedge CLK);
        chk("ld_stall", {63'b0, MEM_STALL}, 64'd1);
        step();
        MEM_FLUSH = 1'b1;
        @(negedge CLK);
        chk("ldf_req1", {63'b0, dmem.DMEM_REQ}, 64'd1);
        step();
        MEM_FLUSH = 1'b0;
        @(negedge CLK);
        chk("ldf_req2", {63'b0, dmem.DMEM_REQ}, 64'd1);
        step();
        dmem.DMEM_READY = 1'b1;
        @(negedge CLK);
        chk("ldf_req3",  {63'b0, dmem.DMEM_REQ}, 64'd1);
        chk("ldf_stall", {63'b0, MEM_STALL}, 64'd0);
        step();
        set_in(1'b0, '0, 3'b000, '0, '0, 1'b0);
        dmem.DMEM_READY = 1'b0;
        @(negedge CLK);
        chk("ldf_wb_v", {63'b0, WB_V}, 64'd0);

        // Reset mid-wait
        step();
        set_in(1'b1, 17'h3, 3'b011, 64'h18, '0, 1'b0);
        step();
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_wb_v",  {63'b0, WB_V}, 64'd0);
        chk("arst_wb_res", WB_RES, 64'd0);
        chk("arst_stall", {63'b0, MEM_STALL}, 64'd0);
        chk("arst_req",   {63'b0, dmem.DMEM_REQ}, 64'd0);
        set_in(1'b0, '0, 3'b000, '0, '0, 1'b0);
        step();
        RESET_N = 1'b1;
        dmem.DMEM_READY = 1'b1;
        @(negedge CLK);
        chk("late_ready_req", {63'b0, dmem.DMEM_REQ}, 64'd0);
        step();
        dmem.DMEM_READY = 1'b0;
        set_in(1'b1, 17'h1, 3'b000, 64'h55AA, '0, 1'b0);
        push(64'h55AA, 17'h1);
        @(negedge CLK);
        chk("post_rst_stall", {63'b0, MEM_STALL}, 64'd0);

        // Invalid slot and flush in IDLE issue nothing
        step();
        set_in(1'b0, 17'h3, 3'b010, 64'h20, '0, 1'b0);
        @(negedge CLK);
        chk("inv_req", {63'b0, dmem.DMEM_REQ}, 64'd0);
        step();
        set_in(1'b1, 17'h3, 3'b010, 64'h20, '0, 1'b1);
        @(negedge CLK);
        chk("flush_req",   {63'b0, dmem.DMEM_REQ}, 64'd0);
        chk("flush_stall", {63'b0, MEM_STALL}, 64'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        step();
        set_in(1'b1, 17'h3, 3'b010, 64'h2, '0, 1'b0);
        push(64'h2, 17'h2);
        @(negedge CLK);
        chk("mis_req",   {63'b0, dmem.DMEM_REQ}, 64'd0);
        chk("mis_stall", {63'b0, MEM_STALL}, 64'd0);
        step();
        set_in(1'b0, '0, 3'b000, '0, '0, 1'b0);
        @(negedge CLK);
        chk("mis_flag", {63'b0, MEM_MISALIGN}, 64'd1);
        step();
        @(negedge CLK);
        chk("mis_flag_clr", {63'b0, MEM_MISALIGN}, 64'd0);
`else
        step();
        set_in(1'b1, 17'h3, 3'b010, 64'h6, '0, 1'b0);
        dmem.DMEM_READY = 1'b1;
        dmem.DMEM_RDATA = 64'h8000_0001_1234_5678;
        push(64'hFFFF_FFFF_8000_0001, 17'h3);
        @(negedge CLK);
        chk("lw_force_be",   {56'b0, dmem.DMEM_BE}, 64'hF0);
        chk("lw_force_addr", dmem.DMEM_ADDR, 64'h0);
        step();
        set_in(1'b1, 17'h3, 3'b101, 64'h7, '0, 1'b0);
        push(64'h8000, 17'h3);
        @(negedge CLK);
        chk("lhu_force_be", {56'b0, dmem.DMEM_BE}, 64'hC0);
`endif

        step();
        set_in(1'b0, '0, 3'b000, '0, '0, 1'b0);
        dmem.DMEM_READY = 1'b0;
        repeat (3) @(negedge CLK);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low: CLK in 1, clock, all state on rising edge; RESET_N in 1, async active-low reset.
REQ-002 Upstream ports SHALL be:
- MEM_V in 1: instruction valid
- MEM_Cst in 17: control; bit0 reg write enable, bit1 load, bit2 store
- MEM_ALU_RES in 64: ALU result / effective address
- MEM_STORE_DATA in 64: rs2 value
- MEM_PC_MUX in 1: redirect
- MEM_NPC in 64: next PC
- MEM_IR in 32: instruction word; funct3 = IR[14:12]
- MEM_Target_Address in 64: branch target
REQ-003 Flush and stall ports SHALL be: MEM_FLUSH in 1, squash the instruction in this stage; MEM_STALL out 1, upstream must hold its MEM_* inputs.
REQ-004 Data memory ports SHALL be:
- DMEM_REQ out 1
- DMEM_WE out 1
- DMEM_ADDR out 64, doubleword-aligned
- DMEM_WDATA out 64, lane-shifted
- DMEM_BE out 8, byte enables
- DMEM_READY in 1
- DMEM_RDATA in 64
REQ-005 Writeback-facing ports SHALL be registered outputs: WB_V 1, WB_Cst 17, WB_RES 64, WB_PC_MUX 1, WB_NPC 64, WB_IR 32, WB_Target_Address 64.

Function
REQ-006 The stage SHALL implement FSM states IDLE and WAIT.
REQ-007 In IDLE, a valid non-memory instruction (MEM_V=1, Cst[2:1]=0, MEM_FLUSH=0) SHALL latch into WB_* at the next edge with WB_RES=MEM_ALU_RES (latency 1).
REQ-008 In IDLE, a valid load or store SHALL assert DMEM_REQ combinationally.
- DMEM_READY=1 in the same cycle: complete in 1 cycle.
- Otherwise: go to WAIT with MEM_STALL=1.
REQ-009 In WAIT, DMEM_REQ, ADDR, WE, BE and WDATA SHALL stay stable until DMEM_READY=1; at that edge WB_* SHALL latch and the FSM SHALL return to IDLE.
REQ-010 MEM_STALL SHALL equal (IDLE and memory op and !DMEM_READY) or (WAIT and !DMEM_READY).
REQ-011 While stalled, WB_V SHALL be 0 (bubble).
REQ-012 Byte enables and lane shift SHALL use funct3[1:0] and addr[2:0]:
- 00: 1 byte, BE = 1<<a
- 01: 2 bytes, BE = 3<<a
- 10: 4 bytes, BE = 0xF<<a
- 11: 8 bytes, BE = 0xFF
WDATA SHALL be the store data shifted left by a*8.
REQ-013 Load data SHALL be right-shifted by a*8, then extended: funct3[2]=0 sign-extends, 1 zero-extends, to 64 bits into WB_RES.
REQ-014 A store SHALL write WB_RES=MEM_ALU_RES; WB_Cst SHALL pass through unchanged.
REQ-015 On MEM_FLUSH=1 in IDLE, no DMEM_REQ SHALL be issued and WB_V SHALL be 0 at the next edge.
REQ-016 On MEM_FLUSH=1 in WAIT, the outstanding access SHALL complete, then the result is discarded (WB_V=0); the flush SHALL be remembered in a sticky flag if it deasserts before READY.
REQ-017 MEM_V=0 SHALL produce WB_V=0 and no DMEM_REQ; the other WB_* fields are don't-care but SHALL still load.

Reset
REQ-018 RESET_N=0 SHALL force: FSM to IDLE, sticky flush flag 0, all WB_* to 0, MEM_STALL=0, DMEM_REQ=0.
REQ-019 Reset during WAIT SHALL abandon the access; a late DMEM_READY after reset SHALL be ignored in IDLE when no request is pending.

Configuration
REQ-020 The macro MEM_MISALIGN_CHECK_EN SHALL control misalignment checking.
- Defined: an access with addr not aligned to its size SHALL issue no DMEM_REQ, SHALL complete in 1 cycle with WB_V=1 and WB_Cst bit0 cleared, and SHALL raise output MEM_MISALIGN (1 bit, registered, reset 0) for one cycle.
- Undefined: the port is absent, addr low bits below the access size are forced to 0, and the access proceeds.

Structure
REQ-021 The shared package SHALL hold the Cst bit-index constants, funct3 size encodings and FSM state typedef.
REQ-022 The combinational sub-module mem_align SHALL generate BE/WDATA and extract load data; the FSM and registers SHALL stay in memory_stage.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ALU op, MEM_ALU_RES=0x1234: next cycle WB_V=1, WB_RES=0x1234, MEM_STALL never 1.
- LB addr 0x...03, RDATA=0x00000000_80000000, READY same cycle: BE=0x08, WB_RES=0xFFFF_FFFF_FFFF_FF80; LBU gives 0x80.
- SW addr 0x4, data 0xDEADBEEF, READY after 3 cycles: MEM_STALL=1 for 3 cycles, BE=0xF0, WDATA[63:32]=0xDEADBEEF stable, WB_V=0 during the stall, then 1.
- LD in WAIT with a 1-cycle MEM_FLUSH pulse, READY 2 cycles later: the access completes, WB_V=0.
- RESET_N low mid-WAIT: all outputs 0 asynchronously, FSM IDLE, a subsequent ALU op flows normally.
- MEM_MISALIGN_CHECK_EN defined, LW addr 0x2: DMEM_REQ=0, MEM_MISALIGN=1 for one cycle, WB_Cst[0]=0.
